prime_sieve_engine: RTL
=======================

# prime_sieve_engine

Memory-mapped, parametrised prime-table generator on the peripheral bus of the SoC. A host writes an upper limit, and a multi-cycle FSM fills an on-chip table with every prime ≤ limit in ascending order. Candidates are tested by trial division against primes already found. The host polls a status register, then reads primes back by index. It supersedes the single-cycle, fixed-size generator: the computation is bounded per cycle, and the block adds busy/done/overflow status, abort, and configurable width and depth.

## Interface
- DATA_W, 32, bus data width (≥ 24)
- LIMIT_W, 10, width of limit and candidate values; max limit 2^LIMIT_W−1
- DEPTH, 256, prime-table entries (power of two, ≤ 2^16)
- iClk  in  1  single clock, rising edge
- iReset_n  in  1  asynchronous, active-low reset
- iChip_select_n  in  1  active-low select
- iWrite_n  in  1  active-low write strobe; read when high and selected
- iData  in  DATA_W  write data
- address  in  3  register select
- oData  out  DATA_W  registered read data

## Operation
- Register map:
  - 0 CTRL (W): iData[LIMIT_W-1:0] = limit. iData[DATA_W-1] = abort.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 overflow, bits[31:16] count.
  - 2 INDEX (W/R): read index, iData[$clog2(DEPTH)-1:0].
  - 3 PRIME (R): table[index] if index < count, else 0.
  - 4 COUNT (R): count, zero-extended.
  - 5–7: reads return 0, writes are ignored.
- CTRL write with abort=0 while idle:
  - Latch limit.
  - Clear count, done and overflow.
  - Set busy and enter INIT.
- CTRL write with abort=0 while busy: ignored entirely.
- CTRL write with abort=1:
  - In any state, go to IDLE.
  - busy=0, done=0; count keeps the number of primes stored so far.
- FSM states:
  - IDLE.
  - INIT: n=2, then CHECK.
  - CHECK:
    - If n > limit: go to IDLE, busy=0, done=1.
    - Otherwise: k=0, then TEST.
  - TEST:
    - One divisor per cycle, p = table[k].
    - If k == count or p*p > n: n is prime, go to STORE.
    - Else if n % p == 0: go to NEXT.
    - Else: k++, stay in TEST.
  - STORE:
    - If count == DEPTH: overflow=1, busy=0, done=1, go to IDLE.
    - Else: table[count] = n, count++, go to NEXT.
  - NEXT:
    - If n == 2^LIMIT_W−1: go to IDLE with done=1 (no wrap).
    - Else: n++, go to CHECK.
- Width rule: p*p is computed at 2·LIMIT_W bits so it never truncates.
- Limit < 2: path INIT → CHECK → IDLE with done=1, count=0.
- Table contents are not cleared on start. Reads at index ≥ count return 0, so stale data is never visible.
- INDEX and PRIME may be read while busy. They return the entry if index < the current count, else 0.
- Bus access rules:
  - Reads update oData only when selected with iWrite_n=1.
  - oData holds its value otherwise, including during writes.
  - Reads have no side effects.

## Timing
- Reset (asynchronous, any state, including mid-generation):
  - oData=0, FSM=IDLE, busy=0, done=0, overflow=0.
  - count=0, limit=0, index=0.
  - Table contents are don't-care, because count=0 masks them.
- Read latency: 1 cycle. A read at edge t is visible on oData after edge t.
- Write to CTRL at edge t: busy=1 is visible to a STATUS read sampled at edge t+1.
- Run time: deterministic. Each composite candidate costs (k_hit+2) cycles; each prime costs (k_stop+3) cycles. Benches poll busy and must not hard-code cycle counts.
- done stays set until the next accepted start, an abort, or reset.

## Test plan
- Basic run:
  - Stimulus: reset, write CTRL=30, poll STATUS until busy=0.
  - Required: done=1, overflow=0, COUNT=10, INDEX=0 gives PRIME=2, INDEX=9 gives PRIME=29, INDEX=10 gives PRIME=0.
- Full range:
  - Stimulus: CTRL=1023 (LIMIT_W=10).
  - Required: COUNT=172, PRIME[171]=1021, no overflow, no wrap of n after 1023.
- Degenerate limits:
  - CTRL=0 → done=1, COUNT=0.
  - CTRL=1 → done=1, COUNT=0.
  - CTRL=2 → COUNT=1, PRIME[0]=2.
- Overflow:
  - Stimulus: DEPTH=8, CTRL=100.
  - Required: done=1, overflow=1, COUNT=8, PRIME[7]=19.
- Start while busy, then abort:
  - CTRL=1023, then CTRL=5 two cycles later → limit stays 1023 and busy stays 1.
  - Then CTRL with bit31=1 → busy=0, done=0 one cycle later, COUNT>0.
  - Then a new CTRL=10 → COUNT=4, PRIME[3]=7.
- Reset mid-operation:
  - Stimulus: assert iReset_n=0 during a 1023 run.
  - Required: oData=0 and STATUS=0 immediately.
  - After release, CTRL=30 produces COUNT=10 and PRIME[9]=29.

Source files
------------

// File: rtl/prime_sieve_engine_if.sv
// Peripheral-bus bundle for the prime sieve engine: chip select, write strobe,
// register address, write data and registered read data.
interface prime_sieve_engine_if #(
    parameter int DATA_W = 32
);
    logic              iChip_select_n;
    logic              iWrite_n;
    logic [2:0]        address;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;

    modport master (
        output iChip_select_n,
        output iWrite_n,
        output address,
        output iData,
        input  oData
    );

    modport slave (
        input  iChip_select_n,
        input  iWrite_n,
        input  address,
        input  iData,
        output oData
    );
endinterface

// File: rtl/prime_sieve_engine.sv
// Prime-table generator: the host writes a limit and the FSM fills the table with
// every prime <= limit, trial-dividing each candidate by the primes found so far.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a start; done/overflow/count hold the last run
// S_INIT  | first candidate n = 2
// S_CHECK | finish when n > limit, else restart divisor index k
// S_TEST  | one divisor table[k] per cycle
// S_STORE | append n to the table, or flag overflow when the table is full
// S_NEXT  | advance to n+1, stopping at the top of the candidate range
module prime_sieve_engine #(
    parameter int DATA_W  = 32,
    parameter int LIMIT_W = 10,
    parameter int DEPTH   = 256
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    prime_sieve_engine_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PROD_W = 2 * LIMIT_W;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CHECK, S_TEST, S_STORE, S_NEXT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LIMIT_W-1:0]  r_limit;
    logic [LIMIT_W-1:0]  r_n;
    logic [CNT_W-1:0]    r_k;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_index;
    logic                r_done;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_odata;
    logic [LIMIT_W-1:0]  r_table [DEPTH];

    logic                w_wr;
    logic                w_rd;
    logic                w_ctrl_wr;
    logic                w_abort;
    logic                w_start;
    logic                w_busy;
    logic [LIMIT_W-1:0]  w_p;
    logic [PROD_W-1:0]   w_p_sq;
    logic                w_divides;
    logic                w_n_init;
    logic                w_n_inc;
    logic                w_k_clr;
    logic                w_k_inc;
    logic                w_store;
    logic                w_set_done;
    logic                w_set_ovf;
    logic [DATA_W-1:0]   w_status;
    logic                w_unused;

    assign w_wr      = !bus.iChip_select_n && !bus.iWrite_n;
    assign w_rd      = !bus.iChip_select_n &&  bus.iWrite_n;
    assign w_ctrl_wr = w_wr && (bus.address == 3'd0);
    assign w_abort   = w_ctrl_wr && bus.iData[DATA_W-1];
    assign w_busy    = (r_state != S_IDLE);
    assign w_start   = w_ctrl_wr && !bus.iData[DATA_W-1] && !w_busy;
    assign w_unused  = ^bus.iData;

    // Divisor under test; p*p is formed at double width so it cannot wrap.
    // A zero divisor only shows up on stale slots that k == count already masks.
    assign w_p       = r_table[r_k[ADDR_W-1:0]];
    assign w_p_sq    = PROD_W'(w_p) * PROD_W'(w_p);
    assign w_divides = (w_p != '0) && ((r_n % w_p) == '0);

    // FSM state register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    // Next-state decode and datapath strobes; abort wins over everything
    always_comb begin
        w_state_next = r_state;
        w_n_init     = 1'b0;
        w_n_inc      = 1'b0;
        w_k_clr      = 1'b0;
        w_k_inc      = 1'b0;
        w_store      = 1'b0;
        w_set_done   = 1'b0;
        w_set_ovf    = 1'b0;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_next = S_INIT;
                S_INIT: begin
                    w_n_init     = 1'b1;
                    w_state_next = S_CHECK;
                end
                S_CHECK: begin
                    if (r_n > r_limit) begin
                        w_set_done   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_k_clr      = 1'b1;
                        w_state_next = S_TEST;
                    end
                end
                S_TEST: begin
                    if ((r_k == r_count) || (w_p_sq > PROD_W'(r_n))) w_state_next = S_STORE;
                    else if (w_divides)                              w_state_next = S_NEXT;
                    else                                             w_k_inc      = 1'b1;
                end
                S_STORE: begin
                    if (r_count == CNT_W'(DEPTH)) begin
                        w_set_ovf    = 1'b1;
                        w_set_done   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_store      = 1'b1;
                        w_state_next = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_n == '1) begin
                        w_set_done   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_n_inc      = 1'b1;
                        w_state_next = S_CHECK;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Run registers: limit, candidate, divisor index, count and status flags
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_limit <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_start) begin
                r_limit <= bus.iData[LIMIT_W-1:0];
                r_count <= '0;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
            end
            if (w_abort)    r_done  <= 1'b0;
            if (w_set_done) r_done  <= 1'b1;
            if (w_set_ovf)  r_ovf   <= 1'b1;
            if (w_n_init)   r_n     <= LIMIT_W'(2);
            if (w_n_inc)    r_n     <= r_n + LIMIT_W'(1);
            if (w_k_clr)    r_k     <= '0;
            if (w_k_inc)    r_k     <= r_k + CNT_W'(1);
            if (w_store)    r_count <= r_count + CNT_W'(1);
        end
    end

    // Prime table; no reset needed since count masks every unwritten slot
    always_ff @(posedge iClk) begin
        if (w_store) r_table[r_count[ADDR_W-1:0]] <= r_n;
    end

    // Host-written read index
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)                           r_index <= '0;
        else if (w_wr && (bus.address == 3'd2))  r_index <= bus.iData[ADDR_W-1:0];
    end

    // STATUS word: busy/done/overflow in the low bits, count from bit 16 up
    always_comb begin
        w_status             = '0;
        w_status[0]          = w_busy;
        w_status[1]          = r_done;
        w_status[2]          = r_ovf;
        w_status[DATA_W-1:16] = (DATA_W-16)'(r_count);
    end

    // Registered read port; holds its value on writes and when deselected
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_odata <= '0;
        end else if (w_rd) begin
            case (bus.address)
                3'd1:    r_odata <= w_status;
                3'd2:    r_odata <= DATA_W'(r_index);
                3'd3:    r_odata <= (CNT_W'(r_index) < r_count) ? DATA_W'(r_table[r_index]) : '0;
                3'd4:    r_odata <= DATA_W'(r_count);
                default: r_odata <= '0;
            endcase
        end
    end

    assign bus.oData = r_odata;
endmodule
